// File: rtl/fifo_ctrl_v2.sv
// fifo_ctrl_v2: parametrised synchronous valid/ready FIFO used as an elastic buffer
// between pipeline stages. It adds an optional bypass, a synchronous flush, an occupancy
// count, almost-full/almost-empty flags and a high-water mark.
//
// Ports:
//   i_clk, i_rst      clock; synchronous active-high reset
//   i_flush           synchronous flush, discards all stored entries
//   i_push_data       upstream data, with i_valid / o_ready handshake
//   o_pop_data        head element or bypassed input, with o_valid / i_ready handshake
//   o_count           entries stored, 0..D
//   o_almost_full     o_count >= AFULL_THRESH
//   o_almost_empty    o_count <= AEMPTY_THRESH
//   o_max_count       highest count reached since the last reset or flush
//
// o_valid never depends on i_ready. When BYPASS_EN=1 and the FIFO is full, o_ready
// follows i_ready so that a push and a pop can happen in the same cycle.
module fifo_ctrl_v2 #(
  parameter int unsigned QUEUE_PTR_BANDWIDTH = 3,
  parameter int unsigned ELE_BANDWIDTH       = 8,
  parameter int unsigned BYPASS_EN           = 1,
  parameter int unsigned AFULL_THRESH        = (2 ** QUEUE_PTR_BANDWIDTH) - 1,
  parameter int unsigned AEMPTY_THRESH       = 1
) (
  input  logic                           i_clk,
  input  logic                           i_rst,
  input  logic                           i_flush,
  input  logic [ELE_BANDWIDTH-1:0]       i_push_data,
  input  logic                           i_valid,
  output logic                           o_ready,
  input  logic                           i_ready,
  output logic                           o_valid,
  output logic [ELE_BANDWIDTH-1:0]       o_pop_data,
  output logic [QUEUE_PTR_BANDWIDTH:0]   o_count,
  output logic                           o_almost_full,
  output logic                           o_almost_empty,
  output logic [QUEUE_PTR_BANDWIDTH:0]   o_max_count
);

  localparam int unsigned P     = QUEUE_PTR_BANDWIDTH;
  localparam int unsigned Depth = 2 ** QUEUE_PTR_BANDWIDTH;

  typedef logic [P:0] ptr_t;

  localparam ptr_t DepthCnt  = ptr_t'(Depth);
  localparam ptr_t AfullTh   = ptr_t'(AFULL_THRESH);
  localparam ptr_t AemptyTh  = ptr_t'(AEMPTY_THRESH);
  localparam bit   Bypass    = (BYPASS_EN != 0);

  logic [ELE_BANDWIDTH-1:0] mem_q [Depth];

  ptr_t head_q, head_d;
  ptr_t tail_q, tail_d;
  ptr_t max_q, max_d;
  ptr_t count, count_d;

  logic empty, full, active;
  logic push, pop, thru, wr_en;

  // Occupancy from the registered pointers. The extra pointer bit tells full from empty.
  always_comb begin
    count  = tail_q - head_q;
    empty  = (count == '0);
    full   = (count == DepthCnt);
    active = ~i_rst & ~i_flush;
  end

  // Handshake outputs. In reset or flush both sides are blocked, so no transfer occurs.
  always_comb begin
    o_valid    = 1'b0;
    o_ready    = 1'b0;
    o_pop_data = mem_q[head_q[P-1:0]];
    if (Bypass && empty) begin
      o_pop_data = i_push_data;
    end
    if (active) begin
      if (Bypass && empty) begin
        o_valid = i_valid;
        o_ready = 1'b1;
      end else begin
        o_valid = ~empty;
        // When full, a pop this cycle frees the slot that the push will fill.
        o_ready = (Bypass && full) ? i_ready : ~full;
      end
    end
  end

  // Pointer next-state
  always_comb begin
    push   = i_valid & o_ready;
    pop    = o_valid & i_ready;
    // A pass-through while empty leaves the storage untouched.
    thru   = Bypass && empty && push && pop;
    wr_en  = push & ~thru;
    head_d = head_q;
    tail_d = tail_q;
    if (pop && !thru) begin
      head_d = head_q + ptr_t'(1);
    end
    if (wr_en) begin
      tail_d = tail_q + ptr_t'(1);
    end
    count_d = tail_d - head_d;
    max_d   = (count_d > max_q) ? count_d : max_q;
  end

  // Status outputs. The count reads as zero while reset is held.
  always_comb begin
    o_count        = i_rst ? '0 : count;
    o_almost_full  = (o_count >= AfullTh);
    o_almost_empty = (o_count <= AemptyTh);
    o_max_count    = max_q;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst || i_flush) begin
      head_q <= '0;
      tail_q <= '0;
      max_q  <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      max_q  <= max_d;
    end
  end

  // Storage is not reset; only the pointers decide which entries are live.
  always_ff @(posedge i_clk) begin
    if (wr_en) begin
      mem_q[tail_q[P-1:0]] <= i_push_data;
    end
  end

endmodule

// File: tb/tb_fifo_ctrl_v2.sv
// tb_fifo_ctrl_v2: self-checking bench for fifo_ctrl_v2. It uses one instance with bypass
// enabled (dut) and one that is fully registered (dut_nb). A scoreboard records every
// accepted push on dut and compares every pop against it. Explicit checks cover the
// counts, flags and handshake values in each scenario.
module tb_fifo_ctrl_v2;

  logic       clk;
  logic       rst;
  logic       flush;
  logic [7:0] data;
  logic       valid;
  logic       ready;
  logic       a_ready, a_valid, a_af, a_ae;
  logic [7:0] a_pop;
  logic [3:0] a_count, a_max;

  logic       b_flush, b_valid, b_ready;
  logic [7:0] b_data;
  logic       b_o_ready, b_o_valid, b_af, b_ae;
  logic [7:0] b_pop;
  logic [3:0] b_count, b_max;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] sb[$];
  logic [7:0] drain_exp [8];

  fifo_ctrl_v2 #(.BYPASS_EN(1)) dut (
    .i_clk(clk), .i_rst(rst), .i_flush(flush), .i_push_data(data), .i_valid(valid),
    .o_ready(a_ready), .i_ready(ready), .o_valid(a_valid), .o_pop_data(a_pop),
    .o_count(a_count), .o_almost_full(a_af), .o_almost_empty(a_ae), .o_max_count(a_max)
  );

  fifo_ctrl_v2 #(.BYPASS_EN(0)) dut_nb (
    .i_clk(clk), .i_rst(rst), .i_flush(b_flush), .i_push_data(b_data), .i_valid(b_valid),
    .o_ready(b_o_ready), .i_ready(b_ready), .o_valid(b_o_valid), .o_pop_data(b_pop),
    .o_count(b_count), .o_almost_full(b_af), .o_almost_empty(b_ae), .o_max_count(b_max)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Inputs change just after posedge, so at negedge they show the transfer that the
  // next posedge will complete.
  always @(negedge clk) begin
    if (rst || flush) begin
      sb.delete();
    end else begin
      if (valid && a_ready) sb.push_back(data);
      if (a_valid && ready) begin
        if (sb.size() == 0) check("sb_underflow", 32'd1, 32'd0);
        else check("sb_pop_data", {24'd0, a_pop}, {24'd0, sb.pop_front()});
      end
    end
  end

  initial begin
    drain_exp = '{8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h3C};
    rst = 1'b1; flush = 1'b0; data = 8'h00; valid = 1'b0; ready = 1'b0;
    b_flush = 1'b0; b_valid = 1'b0; b_ready = 1'b0; b_data = 8'h00;
    repeat (2) tick();

    // Values while reset is held, including with i_valid high
    valid = 1'b1; data = 8'hEE; #1;
    check("rst_valid", a_valid, 0);
    check("rst_ready", a_ready, 0);
    check("rst_count", a_count, 0);
    check("rst_aempty", a_ae, 1);
    check("rst_afull", a_af, 0);
    tick();
    rst = 1'b0; valid = 1'b0; #1;
    check("idle_count", a_count, 0);
    check("idle_max", a_max, 0);
    check("idle_ready", a_ready, 1);

    // Fill with 0x01..0x08 while downstream stalls
    for (int k = 1; k <= 8; k++) begin
      valid = 1'b1; data = 8'(k); ready = 1'b0; #1;
      check("fill_ready", a_ready, 1);
      tick();
      check("fill_count", a_count, k);
      check("fill_afull", a_af, (k >= 7) ? 1 : 0);
      check("fill_max", a_max, k);
    end
    #1;
    check("full_ready", a_ready, 0);
    check("full_valid", a_valid, 1);

    // Push and pop together while full: 0x01 leaves, 0x3C enters
    data = 8'h3C; ready = 1'b1; #1;
    check("fullpp_ready", a_ready, 1);
    check("fullpp_data", a_pop, 8'h01);
    tick();
    valid = 1'b0;
    check("fullpp_count", a_count, 8);

    // Drain
    for (int i = 0; i < 8; i++) begin
      #1;
      check("drain_valid", a_valid, 1);
      check("drain_data", a_pop, drain_exp[i]);
      tick();
      check("drain_count", a_count, 7 - i);
      check("drain_aempty", a_ae, ((7 - i) <= 1) ? 1 : 0);
    end
    #1;
    check("drained_valid", a_valid, 0);
    check("drained_max", a_max, 8);

    // Pass-through while empty
    valid = 1'b1; data = 8'hA5; ready = 1'b1; #1;
    check("thru_valid", a_valid, 1);
    check("thru_data", a_pop, 8'hA5);
    tick();
    check("thru_count", a_count, 0);

    // Empty with a downstream stall: the data is stored, then shown from memory
    data = 8'h5A; ready = 1'b0;
    tick();
    valid = 1'b0; data = 8'h00;
    check("stall_count", a_count, 1);
    #1;
    check("stall_valid", a_valid, 1);
    check("stall_data", a_pop, 8'h5A);
    ready = 1'b1;
    tick();
    check("stall_drain", a_count, 0);

    // Flush at count 5
    ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      valid = 1'b1; data = 8'h10 + 8'(k);
      tick();
    end
    check("preflush_count", a_count, 5);
    flush = 1'b1; data = 8'h66; #1;
    check("flush_ready", a_ready, 0);
    check("flush_valid", a_valid, 0);
    tick();
    flush = 1'b0; valid = 1'b0; #1;
    check("postflush_count", a_count, 0);
    check("postflush_max", a_max, 0);
    check("postflush_valid", a_valid, 0);

    // Reset mid-stream at count 3
    for (int k = 0; k < 3; k++) begin
      valid = 1'b1; data = 8'h20 + 8'(k);
      tick();
    end
    check("prerst_count", a_count, 3);
    rst = 1'b1; data = 8'h99; #1;
    check("midrst_valid", a_valid, 0);
    check("midrst_ready", a_ready, 0);
    check("midrst_count", a_count, 0);
    check("midrst_aempty", a_ae, 1);
    tick();
    rst = 1'b0; valid = 1'b0; #1;
    check("postrst_max", a_max, 0);
    valid = 1'b1; data = 8'h77;
    tick();
    valid = 1'b0; ready = 1'b1; #1;
    check("postrst_head", a_pop, 8'h77);
    check("postrst_count", a_count, 1);
    tick();
    ready = 1'b0;

    // Fully registered instance: one cycle of latency, no pass-through
    b_valid = 1'b1; b_ready = 1'b1; b_data = 8'hA5; #1;
    check("nb_valid0", b_o_valid, 0);
    check("nb_ready0", b_o_ready, 1);
    tick();
    b_valid = 1'b0;
    check("nb_count1", b_count, 1);
    #1;
    check("nb_valid1", b_o_valid, 1);
    check("nb_data1", b_pop, 8'hA5);
    tick();
    check("nb_count2", b_count, 0);
    check("nb_valid2", b_o_valid, 0);

    check("sb_leftover", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
